mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic for the pipelined RISC-V core.
//  - Captures MEM-stage results and extracts/extends load data for LB/LH/LW/LBU/LHU.
//  - Selects ALU, load or PC+4 as the writeback value.
//  - Drives the register-file write port, which writes on the negedge of the same cycle.
//  - Exports wb_* to the forwarding unit.

---
 rtl/mem_wb_stage.sv | 144 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback logic.
// Captures MEM-stage results, extracts and extends load data (LB/LH/LW/LBU/LHU),
// selects the writeback value (ALU, load or PC+4) and drives the register-file
// write port. wb_* come only from registered fields, so the register file's
// negedge write sees stable data.
// Optional feature: define MEM_WB_INSTRET_EN for a 64-bit retired-instruction
// counter on instret; otherwise instret is tied to 0.
module mem_wb_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_result_sel,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_mem_rdata,
  input  logic [XLEN-1:0]    in_pc_plus4,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]    wb_data,
  output logic               wb_valid,
  output logic [63:0]        instret
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_PC4  = 2'd2,
    SEL_RSVD = 2'd3
  } result_sel_e;

  // RV32I load funct3 codes; any other code reads the full word.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_op_e;

  // Stage register fields
  logic               r_valid;
  logic               r_reg_write;
  logic [RADDR_W-1:0] r_rd;
  result_sel_e        r_result_sel;
  logic [2:0]         r_funct3;
  logic [XLEN-1:0]    r_alu;
  logic [XLEN-1:0]    r_mem;
  logic [XLEN-1:0]    r_pc4;

  // Combinational writeback signals
  logic [1:0]         w_off;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [XLEN-1:0]    w_load;
  logic [XLEN-1:0]    w_result;
  logic               w_en;

  // Stage register update: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_result_sel <= SEL_ALU;
      r_funct3     <= '0;
      r_alu        <= '0;
      r_mem        <= '0;
      r_pc4        <= '0;
    end else if (!stall) begin
      r_valid      <= in_valid;
      r_reg_write  <= in_reg_write;
      r_rd         <= in_rd;
      r_result_sel <= result_sel_e'(in_result_sel);
      r_funct3     <= in_funct3;
      r_alu        <= in_alu_result;
      r_mem        <= in_mem_rdata;
      r_pc4        <= in_pc_plus4;
    end
  end

  // Byte and halfword lane selection from the effective address offset
  always_comb begin
    w_off = r_alu[1:0];
    case (w_off)
      2'd0:    w_byte = r_mem[7:0];
      2'd1:    w_byte = r_mem[15:8];
      2'd2:    w_byte = r_mem[23:16];
      default: w_byte = r_mem[31:24];
    endcase
    // Misaligned halfword: off[0] is ignored, no trap.
    w_half = w_off[1] ? r_mem[31:16] : r_mem[15:0];
  end

  // Load sign/zero extension by funct3
  always_comb begin
    case (r_funct3)
      F3_LB:   w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   w_load = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = r_mem;
    endcase
  end

  // Writeback value select and register-file port
  always_comb begin
    case (r_result_sel)
      SEL_ALU:  w_result = r_alu;
      SEL_LOAD: w_result = w_load;
      SEL_PC4:  w_result = r_pc4;
      default:  w_result = '0;
    endcase
    w_en     = r_valid && r_reg_write && (r_rd != '0);
    wb_en    = w_en;
    wb_addr  = w_en ? r_rd : '0;
    wb_data  = w_en ? w_result : '0;
    wb_valid = r_valid;
  end

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] r_instret;

  // Count each retiring instruction once: only on the non-stalled cycle it leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_valid && !stall) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literal cases plus randomized
// traffic compared every cycle against a behavioural writeback model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4;
  logic        wb_en, wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  // Model: what wb_* must show for the instruction held in the stage
  bit          m_known = 1'b0;
  bit          m_valid, m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  longint unsigned m_instret = 0;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_result_sel(in_result_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_valid(wb_valid), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Writeback value from the architectural definition of each instruction type
  function automatic logic [31:0] ref_value(input logic [1:0] sel, input logic [2:0] f3,
                                            input logic [31:0] alu, input logic [31:0] mem,
                                            input logic [31:0] pc4);
    int unsigned off;
    logic [31:0] v;
    off = alu % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (mem >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (mem >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end
      default: v = mem;
    endcase
    case (sel)
      2'd0:    return alu;
      2'd1:    return v;
      2'd2:    return pc4;
      default: return 32'd0;
    endcase
  endfunction

  // Model update at each capture edge
  always @(posedge clk) begin
    if (rst) m_instret = 0;
    else if (m_known && m_valid && !stall) m_instret = m_instret + 1;
    if (rst || flush) begin
      m_valid = 0; m_en = 0; m_addr = '0; m_data = '0;
      if (rst) m_known = 1'b1;
    end else if (!stall) begin
      m_valid = in_valid;
      m_en    = in_valid && in_reg_write && (in_rd != 5'd0);
      m_addr  = m_en ? in_rd : 5'd0;
      m_data  = m_en ? ref_value(in_result_sel, in_funct3, in_alu_result,
                                 in_mem_rdata, in_pc_plus4) : 32'd0;
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
      chk("wb_en",    {63'd0, wb_en},    {63'd0, m_en});
      chk("wb_addr",  {59'd0, wb_addr},  {59'd0, m_addr});
      chk("wb_data",  {32'd0, wb_data},  {32'd0, m_data});
`ifdef MEM_WB_INSTRET_EN
      chk("instret",  instret, m_instret);
`else
      chk("instret_tied", instret, 64'd0);
`endif
    end
  end

  task automatic randomize_inputs();
    in_valid      = 1'($urandom);
    in_reg_write  = 1'($urandom);
    in_rd         = 5'($urandom);
    in_result_sel = 2'($urandom);
    in_funct3     = 3'($urandom);
    in_alu_result = $urandom;
    in_mem_rdata  = $urandom;
    in_pc_plus4   = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
    rst = 0; stall = 0; flush = 0;
    in_valid = 1; in_reg_write = rw; in_rd = rd; in_result_sel = sel;
    in_funct3 = f3; in_alu_result = alu; in_mem_rdata = mem; in_pc_plus4 = pc4;
    step();
  endtask

  task automatic load_case(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    issue(1'b1, 5'd3, 2'd1, f3, 32'h0000_1000 | {30'd0, off}, 32'h80FF_7F01, 32'h0);
    chk(name, {32'd0, wb_data}, {32'd0, exp});
  endtask

  initial begin
    // Reset with random inputs
    rst = 1; stall = 0; flush = 0;
    randomize_inputs();
    step();
    chk("rst1_en", {63'd0, wb_en}, 64'd0);
    randomize_inputs();
    stall = 1'($urandom); flush = 1'($urandom);
    step();
    chk("rst2_en",    {63'd0, wb_en},    64'd0);
    chk("rst2_addr",  {59'd0, wb_addr},  64'd0);
    chk("rst2_data",  {32'd0, wb_data},  64'd0);
    chk("rst2_valid", {63'd0, wb_valid}, 64'd0);

    // ALU writeback
    issue(1'b1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'hDEAD_BEEF, 32'h40);
    chk("alu_en",   {63'd0, wb_en},   64'd1);
    chk("alu_addr", {59'd0, wb_addr}, 64'd5);
    chk("alu_data", {32'd0, wb_data}, 64'h1234);

    // Loads from 0x80FF7F01
    load_case("lb_off1",  3'b000, 2'd1, 32'h0000_007F);
    load_case("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
    load_case("lbu_off2", 3'b100, 2'd2, 32'h0000_00FF);
    load_case("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
    load_case("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
    load_case("lh_off3",  3'b001, 2'd3, 32'hFFFF_80FF);
    load_case("lw_off1",  3'b010, 2'd1, 32'h80FF_7F01);

    // rd=0 never writes; JAL link value
    issue(1'b1, 5'd0, 2'd0, 3'd0, 32'h5555, 32'h0, 32'h0);
    chk("rd0_en",    {63'd0, wb_en},    64'd0);
    chk("rd0_data",  {32'd0, wb_data},  64'd0);
    chk("rd0_valid", {63'd0, wb_valid}, 64'd1);
    issue(1'b1, 5'd1, 2'd2, 3'd0, 32'h9999, 32'h0, 32'h104);
    chk("jal_data", {32'd0, wb_data}, 64'h104);
    chk("jal_addr", {59'd0, wb_addr}, 64'd1);
    issue(1'b1, 5'd9, 2'd3, 3'd0, 32'h9999, 32'h7, 32'h104);
    chk("rsvd_data", {32'd0, wb_data}, 64'd0);

    // Stall holds, flush beats stall
    issue(1'b1, 5'd7, 2'd0, 3'd0, 32'hCAFE, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1;
      step();
      chk("stall_data", {32'd0, wb_data}, 64'hCAFE);
      chk("stall_addr", {59'd0, wb_addr}, 64'd7);
    end
    stall = 1; flush = 1;
    step();
    chk("flush_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_en",    {63'd0, wb_en},    64'd0);
    flush = 0; stall = 0;

`ifdef MEM_WB_INSTRET_EN
    // Ten retirements, one stalled for three cycles, then a flushed bubble
    rst = 1; step(); rst = 0;
    chk("instret_rst", instret, 64'd0);
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 5'(i + 1), 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
      if (i == 2) begin
        stall = 1;
        for (int s = 0; s < 3; s++) step();
        stall = 0;
      end
    end
    flush = 1; in_valid = 1; step();
    flush = 0; in_valid = 0;
    step(); step();
    chk("instret_ten", instret, 64'd10);

    // Wrap from all ones
    issue(1'b1, 5'd4, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    stall = 0; in_valid = 0;
    step();
    chk("instret_wrap", instret, 64'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) in_result_sel = 2'd1;
      step();
    end
    rst = 0; stall = 0; flush = 0;
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
